// File: rtl/mmio_io_bridge_if.sv
// Load/store and board I/O signal bundle between the core side and the MMIO bridge.
// The master side drives the core request and the raw board inputs.
interface mmio_io_bridge_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N_IN   = 3,
   parameter int unsigned IN_W   = 5,
   parameter int unsigned N_OUT  = 2,
   parameter int unsigned OUT_W  = 15
);
   logic                    rd_en;
   logic                    wr_en;
   logic [ADDR_W-1:0]       addr;
   logic [DATA_W-1:0]       wdata;
   logic [DATA_W-1:0]       rdata;
   logic                    hit;
   logic                    mem_we;
   logic [N_IN*IN_W-1:0]    in_bus;
   logic [N_OUT*OUT_W-1:0]  out_bus;

   modport master (
      output rd_en, wr_en, addr, wdata, in_bus,
      input  rdata, hit, mem_we, out_bus
   );

   modport slave (
      input  rd_en, wr_en, addr, wdata, in_bus,
      output rdata, hit, mem_we, out_bus
   );
endinterface

// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O window beside dmem: debounced input channels, writable output
// registers, and a sticky clear-on-read rising-edge register for the last input channel.
module mmio_io_bridge #(
   parameter int unsigned      ADDR_W     = 32,
   parameter int unsigned      DATA_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(4064),
   parameter int unsigned      N_IN       = 3,
   parameter int unsigned      IN_W       = 5,
   parameter int unsigned      N_OUT      = 2,
   parameter int unsigned      OUT_W      = 15,
   parameter int unsigned      DEB_CYCLES = 4
) (
   input logic             clk,
   input logic             reset,
   mmio_io_bridge_if.slave bus
);
   localparam int unsigned CNT_W     = $clog2(DEB_CYCLES + 1);
   localparam int unsigned WORD_W    = ADDR_W - 2;
   localparam int unsigned EDGE_IDX  = N_IN + N_OUT;
   localparam int unsigned WIN_BYTES = 4 * (N_IN + N_OUT + 1);
   localparam int unsigned LAST      = N_IN - 1;

   logic [ADDR_W-1:0]      offset;
   logic [WORD_W-1:0]      word;
   logic                   aligned;
   logic                   sel_edge;
   logic [N_IN-1:0]        accept;
   logic [IN_W-1:0]        rise;

   logic [IN_W-1:0]        s1_q     [N_IN];
   logic [IN_W-1:0]        s2_q     [N_IN];
   logic [IN_W-1:0]        stable_q [N_IN];
   logic [CNT_W-1:0]       cnt_q    [N_IN];
   logic [IN_W-1:0]        edge_q;
   logic [N_OUT*OUT_W-1:0] out_q;

   // Window decode; misaligned addresses hit but select nothing
   assign offset     = bus.addr - BASE_ADDR;
   assign bus.hit    = (bus.addr >= BASE_ADDR) && (offset < ADDR_W'(WIN_BYTES));
   assign aligned    = bus.hit && (offset[1:0] == 2'b00);
   assign word       = offset[ADDR_W-1:2];
   assign sel_edge   = aligned && (word == WORD_W'(EDGE_IDX));
   assign bus.mem_we = bus.wr_en && !bus.hit;
   assign bus.out_bus = out_q;

   always_comb begin
      accept = '0;
      for (int k = 0; k < N_IN; k++) begin
         accept[k] = (s2_q[k] != stable_q[k]) && (cnt_q[k] == CNT_W'(DEB_CYCLES - 1));
      end
   end

   assign rise = accept[LAST] ? (s2_q[LAST] & ~stable_q[LAST]) : '0;

   // Synchroniser, debounce and edge capture
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < N_IN; k++) begin
            s1_q[k]     <= '0;
            s2_q[k]     <= '0;
            stable_q[k] <= '0;
            cnt_q[k]    <= '0;
         end
         edge_q <= '0;
      end else begin
         for (int k = 0; k < N_IN; k++) begin
            s1_q[k] <= bus.in_bus[k*IN_W +: IN_W];
            s2_q[k] <= s1_q[k];
            if (s2_q[k] == stable_q[k]) begin
               cnt_q[k] <= '0;
            end else if (accept[k]) begin
               stable_q[k] <= s2_q[k];
               cnt_q[k]    <= '0;
            end else begin
               cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
         end
         // A read clears old edges but keeps one arriving in the same cycle
         edge_q <= (bus.rd_en && sel_edge) ? rise : (edge_q | rise);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_q <= '0;
      end else begin
         for (int j = 0; j < N_OUT; j++) begin
            if (bus.wr_en && aligned && (word == WORD_W'(N_IN + j))) begin
               out_q[j*OUT_W +: OUT_W] <= bus.wdata[OUT_W-1:0];
            end
         end
      end
   end

   // Read mux depends on address only
   always_comb begin
      bus.rdata = '0;
      if (aligned) begin
         for (int k = 0; k < N_IN; k++) begin
            if (word == WORD_W'(k)) bus.rdata = DATA_W'(stable_q[k]);
         end
         for (int j = 0; j < N_OUT; j++) begin
            if (word == WORD_W'(N_IN + j)) bus.rdata = DATA_W'(out_q[j*OUT_W +: OUT_W]);
         end
         if (sel_edge) bus.rdata = DATA_W'(edge_q);
      end
   end

   generate
      if (OUT_W < DATA_W) begin : g_wdata_sink
         logic unused_wdata;
         assign unused_wdata = ^bus.wdata[DATA_W-1:OUT_W];
      end
   endgenerate
endmodule

// File: doc/mmio_io_bridge.md
Name: mmio_io_bridge

Overview:
- Parametrised memory-mapped I/O bridge between the single-cycle MIPS core's load/store path and board I/O.
- Generalises the fixed LW/SW address decoder to N_IN input channels and N_OUT output registers at a configurable base address.
- Adds input synchronisation, per-channel debounce, and a sticky clear-on-read rising-edge register for the last input channel (buttons).
- Sits beside dmem: the core muxes rdata over memory read data when hit=1; dmem write enable is mem_we.

Parameters:
- ADDR_W, 32, width of addr.
- DATA_W, 32, width of wdata/rdata.
- BASE_ADDR, 32'd4064, word-aligned start of the I/O window.
- N_IN, 3, number of input channels (1..8).
- IN_W, 5, bits per input channel (<= DATA_W).
- N_OUT, 2, number of output registers (1..8).
- OUT_W, 15, bits per output register (<= DATA_W).
- DEB_CYCLES, 4, stable cycles required before an input change is accepted (>= 1).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- rd_en  in  1  load in progress (core lw flag).
- wr_en  in  1  store in progress (core MemWrite).
- addr  in  ADDR_W  ALU result (effective address).
- wdata  in  DATA_W  store data (RD2).
- rdata  out  DATA_W  I/O read data, combinational.
- hit  out  1  addr lies inside the I/O window.
- mem_we  out  1  wr_en & ~hit, to dmem write.
- in_bus  in  N_IN*IN_W  raw asynchronous inputs; channel k at [k*IN_W +: IN_W].
- out_bus  out  N_OUT*OUT_W  output registers; channel j at [j*OUT_W +: OUT_W].

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-low: reset==0 sampled at posedge clears everything below.
- Address map, in words from BASE_ADDR:
  - IN k at BASE+4k (read-only).
  - OUT j at BASE+4(N_IN+j) (read/write).
  - EDGE at BASE+4(N_IN+N_OUT) (read, clear-on-read).
  - Window size is 4(N_IN+N_OUT+1) bytes.
- hit (combinational): BASE <= addr < BASE+window, independent of rd_en/wr_en. Misaligned addr (addr[1:0]!=0) inside the window still asserts hit but selects no register.
- rdata: a function of addr only (rd_en is used solely for the EDGE clear).
  - IN k: zero-extended stable_k.
  - OUT j: zero-extended readback of out_j.
  - EDGE: zero-extended edge_q.
  - Otherwise (miss, misaligned): 0.
- Input path, per channel:
  - Two-flop synchroniser s1 -> s2.
  - Debounce counter cnt, width clog2(DEB_CYCLES+1). Each posedge:
    - s2==stable: cnt<=0.
    - else cnt==DEB_CYCLES-1: stable<=s2, cnt<=0.
    - else cnt<=cnt+1.
  - Timing: an input held from before edge 0 appears in stable after edge DEB_CYCLES+1. Any revert before then clears cnt with no update.
- Edge capture, channel N_IN-1: rise = stable_new & ~stable_old, per bit, in the cycle stable updates.
  - Read hit on EDGE with rd_en=1: edge_q <= rise. Read returns the old value; a coincident new edge is kept.
  - Otherwise: edge_q <= edge_q | rise.
- Writes: wr_en & aligned hit on OUT j -> out_j <= wdata[OUT_W-1:0] at posedge. Writes to IN/EDGE/misaligned are ignored. mem_we=0 whenever hit=1.
- rd_en & wr_en together: both act; the read sees pre-edge values.
- Reset values: out_bus=0, s1/s2/stable=0, cnt=0, edge_q=0. Reset mid-debounce discards the pending change. rdata/hit/mem_we stay combinational during reset.
- Latency:
  - Output write visible on out_bus one cycle after the store cycle.
  - Input visible after DEB_CYCLES+2 edges from the async change, worst case.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_bus non-zero -> out_bus=0; read 4064/4068/4072/4084 all give 0.
- Store: wr_en=1, addr=4076, wdata=32'hFFFF_ABCD -> after the edge out_bus[14:0]=15'h2BCD; read 4076 gives 32'h0000_2BCD. Same store to addr 4000 -> hit=0, mem_we=1, out_bus unchanged.
- Debounce: in0 4'hA applied before edge 0 -> read 4064 gives 0 through edge 4, 32'hA after edge 5. A 3-cycle glitch on in1 -> 4068 never changes.
- Edge capture: C button bit0 rises and debounces -> read 4084 gives 1. Next-cycle read gives 0; bit stays 1 on repeated sampling until read.
- Edge collision: read of 4084 in the same cycle a bit2 rise is accepted -> read returns the old value; a subsequent read returns 32'h4.
- Illegal accesses: store to 4064 or 4085 -> hit=1, mem_we=0, no register change. rd_en&wr_en on 4080 -> read shows old value, register updated after the edge.
